truth_table_sweeper: RTL
========================

# truth_table_sweeper

Parametrised sequential truth-table engine for N-input boolean functions. It latches a function given as a 2^N-bit minterm mask and sweeps every input combination in ascending order, one row per cycle. Each selected row is presented on a valid/ready stream, and the block counts the function's minterms. It sits between a function source (a SoP/PoS mask generator or register) and a row consumer (display/logging/checker).

## Interface
Parameters:
- N, default 3, number of function inputs; legal 1..8; table width T = 2^N.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a sweep; sampled only in IDLE.
- table_in  in  T  function mask; bit i = f(row i), row i = binary value of inputs with x as MSB.
- mode  in  2  row filter: 0 = all rows, 1 = minterms only (f=1), 2 = maxterms only (f=0), 3 = treated as 0.
- row_valid  out  1  current row is offered.
- row_ready  in  1  consumer accepts the row.
- row_x  out  N  input combination of the current row.
- row_f  out  1  function value of the current row.
- busy  out  1  high in SWEEP and DONE.
- done  out  1  one-cycle pulse at end of sweep.
- minterm_count  out  N+1  number of ones in the latched table.

## Operation
- State machine: IDLE, SWEEP, DONE. All registers clear asynchronously when rst_n = 0: state = IDLE, idx = 0, latched table = 0, latched mode = 0, count = 0. All outputs are 0 during reset.
- IDLE, start = 1: latch table_in and mode, clear count, set idx = 0, go to SWEEP. After start is sampled, table_in and mode changes have no effect until the next sweep.
- SWEEP outputs: row_x = idx, row_f = tbl[idx]. row_valid = pass(idx), where pass is the mode filter applied to tbl[idx].
- Advance condition is !pass(idx) OR row_ready. Filtered rows consume exactly one cycle with row_valid = 0.
- On advance: if tbl[idx] = 1, count += 1. If idx = T-1, go to DONE; otherwise idx += 1.
- While row_valid = 1 and row_ready = 0: row_x, row_f and row_valid hold stable. No row is skipped or duplicated.
- DONE: done = 1 for one cycle, then IDLE.
- minterm_count = count register. It is final in DONE and holds until the next accepted start.
- start is ignored in SWEEP and DONE. A start asserted during DONE is not queued.
- Outside SWEEP, row_x, row_f and row_valid are 0.
- count width N+1 holds T exactly (all-ones table); it never wraps.

## Timing
- start sampled high at edge k: SWEEP begins at k+1 with idx = 0. The first row is visible in the cycle after edge k.
- Without back-pressure, SWEEP lasts exactly T cycles regardless of mode, and done is high in the cycle after edge k+T.
- Each stalled cycle (row_valid = 1, row_ready = 0) delays done by one cycle.
- row_valid is combinational from registered state and is not combinationally dependent on row_ready. row_ready affects only the next state.
- Back-to-back sweeps: the earliest restart is start in the IDLE cycle right after DONE, giving a minimum gap of 2 cycles between sweeps.
- rst_n low mid-sweep clears immediately, with no done pulse. After rst_n rises, the block waits in IDLE for a new start.

## Test plan
- N=3, table_in=8'h98 (f = x'yz + xy'z' + xyz), mode 0, row_ready=1: rows 0..7 give f = 0,0,0,1,1,0,0,1; row_valid high all 8 cycles; done 8 cycles after SWEEP entry; minterm_count = 3.
- Same table, mode 1: row_valid high only at row_x = 3, 4, 7; sweep still 8 cycles; count = 3. Mode 2: valid at rows 0, 1, 2, 5, 6.
- Back-pressure, mode 0: row_ready low for 3 cycles while row_x = 3. Required: row_x = 3 and row_f = 1 stay stable; done delayed by exactly 3 cycles; count still 3.
- Edge tables, mode 1: table 8'h00 gives no row_valid, count 0, done after 8 cycles. Table 8'hFF gives count = 8 with no wrap.
- Robustness:
  - start and table_in toggled mid-sweep: ignored.
  - rst_n pulsed low at row 5: all outputs are 0 immediately, no done pulse; a fresh start then sweeps from row 0.
- N=4, table 16'h8001, mode 1: valid only at row_x = 0 and 15; count = 2; done after 16 cycles.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sequential truth-table engine: latches a 2^N-bit minterm mask and
// streams every row in ascending order while counting the minterms.
module truth_table_sweeper #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [(1<<N)-1:0]   table_in,
  input  logic [1:0]          mode,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [N-1:0]        row_x,
  output logic                row_f,
  output logic                busy,
  output logic                done,
  output logic [N:0]          minterm_count
);

  localparam int T = 1 << N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [N-1:0]   idx;
  logic [T-1:0]   tbl;
  logic [1:0]     mode_q;
  logic [N:0]     count;

  logic           in_sweep;
  logic           cur_f;
  logic           pass;
  logic           adv;
  logic           last_row;

  assign in_sweep = (state == SWEEP);
  assign cur_f    = tbl[idx];
  assign last_row = &idx;

  // Mode 3 behaves like mode 0: every row is offered.
  always_comb begin
    pass = 1'b1;
    unique case (mode_q)
      2'd1:    pass = cur_f;
      2'd2:    pass = !cur_f;
      default: pass = 1'b1;
    endcase
  end

  // Filtered rows never wait on the consumer.
  assign adv = in_sweep && (!pass || row_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SWEEP;
      SWEEP:   if (adv && last_row) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      tbl    <= '0;
      mode_q <= '0;
      count  <= '0;
    end else if (state == IDLE && start) begin
      idx    <= '0;
      tbl    <= table_in;
      mode_q <= mode;
      count  <= '0;
    end else if (adv) begin
      if (cur_f) count <= count + (N+1)'(1);
      if (!last_row) idx <= idx + N'(1);
    end
  end

  assign row_valid     = in_sweep && pass;
  assign row_x         = in_sweep ? idx : '0;
  assign row_f         = in_sweep && cur_f;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign minterm_count = count;

endmodule
